// File: rtl/lookup_merge.sv
// lookup_merge: aligns per-channel countid streams in small FIFOs and merges one
// entry from every enabled channel into a single registered countid result.
module lookup_merge #(
    parameter int                  NUM_CH   = 4,
    parameter int                  WIDTH_ID = 6,
    parameter int                  DEPTH    = 8,
    parameter logic [WIDTH_ID-1:0] MISS_ID  = '1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_CH-1:0]            lk_valid,
    input  logic [NUM_CH*WIDTH_ID-1:0]   lk_id,
    input  logic [NUM_CH-1:0]            ch_enable,
    input  logic [1:0]                   mode,
    input  logic                         rule_ready,
    output logic                         countid_valid,
    output logic [WIDTH_ID-1:0]          countid,
    output logic [NUM_CH-1:0]            hit_map,
    output logic                         merge_busy,
    output logic [NUM_CH-1:0]            overflow_err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] BUSY_LVL = PTR_W'(DEPTH - 2);

    logic [NUM_CH-1:0]   push;
    logic [NUM_CH-1:0]   pop;
    logic [NUM_CH-1:0]   full;
    logic [NUM_CH-1:0]   empty;
    logic [WIDTH_ID-1:0] head [NUM_CH];
    logic [PTR_W-1:0]    occ_d [NUM_CH];
    logic                merge;

    assign merge = (|ch_enable) && (&(~ch_enable | ~empty)) && rule_ready;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH_ID-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
        logic                ovf_q, ovf_d;

        // Extra pointer MSB distinguishes full from empty when the index bits match.
        assign empty[gi] = (wr_ptr_q == rd_ptr_q);
        assign full[gi]  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                           (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
        assign head[gi]  = mem_q[rd_ptr_q[ADDR_W-1:0]];
        assign pop[gi]   = merge & ch_enable[gi];
        assign push[gi]  = lk_valid[gi] & ch_enable[gi] & (~full[gi] | pop[gi]);

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            ovf_d    = ovf_q;
            if (!ch_enable[gi]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end else begin
                if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
                if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
                if (lk_valid[gi] && full[gi] && !pop[gi]) ovf_d = 1'b1;
            end
        end

        assign occ_d[gi] = wr_ptr_d - rd_ptr_d;

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                ovf_q    <= ovf_d;
            end
        end

        always_ff @(posedge clk) begin
            if (push[gi] && !reset)
                mem_q[wr_ptr_q[ADDR_W-1:0]] <= lk_id[gi*WIDTH_ID +: WIDTH_ID];
        end

        assign overflow_err[gi] = ovf_q;
    end

    logic [WIDTH_ID-1:0] and_v, min_v, pri_v, merged;
    logic                found;
    logic [NUM_CH-1:0]   hit_now;

    always_comb begin
        and_v   = '1;
        min_v   = '1;
        pri_v   = MISS_ID;
        found   = 1'b0;
        hit_now = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_enable[i]) begin
                and_v      = and_v & head[i];
                hit_now[i] = (head[i] != MISS_ID);
                if (head[i] < min_v) min_v = head[i];
                if (!found && head[i] != MISS_ID) begin
                    pri_v = head[i];
                    found = 1'b1;
                end
            end
        end
        case (mode)
            2'd1:    merged = pri_v;
            2'd2:    merged = min_v;
            default: merged = and_v;
        endcase
    end

    logic                countid_valid_q, countid_valid_d;
    logic [WIDTH_ID-1:0] countid_q, countid_d;
    logic [NUM_CH-1:0]   hit_map_q, hit_map_d;
    logic                merge_busy_q, merge_busy_d;

    always_comb begin
        countid_valid_d = merge;
        countid_d       = merge ? merged : countid_q;
        hit_map_d       = merge ? hit_now : hit_map_q;
        // Busy reflects the occupancy the FIFOs will hold after this edge.
        merge_busy_d    = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (occ_d[i] >= BUSY_LVL) merge_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countid_valid_q <= 1'b0;
            countid_q       <= '0;
            hit_map_q       <= '0;
            merge_busy_q    <= 1'b0;
        end else begin
            countid_valid_q <= countid_valid_d;
            countid_q       <= countid_d;
            hit_map_q       <= hit_map_d;
            merge_busy_q    <= merge_busy_d;
        end
    end

    assign countid_valid = countid_valid_q;
    assign countid       = countid_q;
    assign hit_map       = hit_map_q;
    assign merge_busy    = merge_busy_q;
endmodule
